// File: rtl/pc_jump_sequencer.sv
// PC control sequencer: resolves SEQ/JMP/JZ/CALL/RET/HALT into PC control codes,
// keeps a return-address stack and inserts one flush cycle after every taken transfer.
module pc_jump_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int DEPTH_W     = 3
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Start,
  input  logic              i_Instr_Valid,
  input  logic [2:0]        i_Op,
  input  logic              i_Flag_Z,
  input  logic [ADDR_W-1:0] i_Target,
  input  logic [ADDR_W-1:0] i_Pc_Actual,
  output logic              o_Control_PC,
  output logic [1:0]        o_Control_Saltos,
  output logic [ADDR_W-1:0] o_Direccion_Salto,
  output logic              o_Flush,
  output logic              o_Halted,
  output logic              o_Stack_Overflow,
  output logic              o_Stack_Underflow,
  output logic [DEPTH_W-1:0] o_Depth
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

  localparam logic [2:0] OP_SEQ  = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_JZ   = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b101;

  localparam logic [1:0] SALTOS_INC  = 2'b00;
  localparam logic [1:0] SALTOS_LOAD = 2'b01;
  localparam logic [1:0] SALTOS_HOLD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_FLUSH = 3'd2,
    S_HALT  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t            r_State;
  state_t            w_NextState;
  logic [ADDR_W-1:0] r_Stack [STACK_DEPTH];
  logic [DEPTH_W-1:0] r_Depth;
  logic              r_Overflow;
  logic              r_Underflow;

  logic              w_Push;
  logic              w_Pop;
  logic              w_SetOverflow;
  logic              w_SetUnderflow;
  logic [IDX_W-1:0]  w_PushIdx;
  logic [IDX_W-1:0]  w_TopIdx;
  logic [ADDR_W-1:0] w_RetAddr;
  logic [ADDR_W-1:0] w_TopAddr;
  logic              w_StackFull;
  logic              w_StackEmpty;

  // Push slot is the current occupancy; the top entry sits one below it.
  assign w_PushIdx    = r_Depth[IDX_W-1:0];
  assign w_TopIdx     = w_PushIdx - IDX_W'(1);
  assign w_TopAddr    = r_Stack[w_TopIdx];
  assign w_RetAddr    = i_Pc_Actual + ADDR_W'(1);
  assign w_StackFull  = (r_Depth >= DEPTH_FULL);
  assign w_StackEmpty = (r_Depth == '0);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State <= S_IDLE;
    end else begin
      r_State <= w_NextState;
    end
  end

  always_comb begin
    w_NextState       = r_State;
    o_Control_PC      = 1'b0;
    o_Control_Saltos  = SALTOS_HOLD;
    o_Direccion_Salto = '0;
    o_Flush           = 1'b0;
    o_Halted          = 1'b0;
    w_Push            = 1'b0;
    w_Pop             = 1'b0;
    w_SetOverflow     = 1'b0;
    w_SetUnderflow    = 1'b0;

    case (r_State)
      S_IDLE: begin
        if (i_Start) begin
          w_NextState = S_RUN;
        end
      end

      S_RUN: begin
        if (i_Instr_Valid) begin
          case (i_Op)
            OP_JMP: begin
              o_Control_Saltos  = SALTOS_LOAD;
              o_Direccion_Salto = i_Target;
              w_NextState       = S_FLUSH;
            end
            OP_JZ: begin
              if (i_Flag_Z) begin
                o_Control_Saltos  = SALTOS_LOAD;
                o_Direccion_Salto = i_Target;
                w_NextState       = S_FLUSH;
              end else begin
                o_Control_PC     = 1'b1;
                o_Control_Saltos = SALTOS_INC;
              end
            end
            OP_CALL: begin
              if (!w_StackFull) begin
                w_Push            = 1'b1;
                o_Control_Saltos  = SALTOS_LOAD;
                o_Direccion_Salto = i_Target;
                w_NextState       = S_FLUSH;
              end else begin
                w_SetOverflow = 1'b1;
                w_NextState   = S_FAULT;
              end
            end
            OP_RET: begin
              if (!w_StackEmpty) begin
                w_Pop             = 1'b1;
                o_Control_Saltos  = SALTOS_LOAD;
                o_Direccion_Salto = w_TopAddr;
                w_NextState       = S_FLUSH;
              end else begin
                w_SetUnderflow = 1'b1;
                w_NextState    = S_FAULT;
              end
            end
            OP_HALT: begin
              w_NextState = S_HALT;
            end
            default: begin
              // SEQ and the unused 11x codes both advance the PC by one.
              o_Control_PC     = 1'b1;
              o_Control_Saltos = SALTOS_INC;
            end
          endcase
        end
      end

      S_FLUSH: begin
        o_Flush     = 1'b1;
        w_NextState = S_RUN;
      end

      S_HALT: begin
        o_Halted = 1'b1;
      end

      S_FAULT: begin
        w_NextState = S_FAULT;
      end

      default: begin
        w_NextState = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Depth <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        r_Stack[i] <= '0;
      end
    end else if (w_Push) begin
      r_Stack[w_PushIdx] <= w_RetAddr;
      r_Depth            <= r_Depth + DEPTH_W'(1);
    end else if (w_Pop) begin
      r_Depth <= r_Depth - DEPTH_W'(1);
    end
  end

  // Fault flags stay set until reset so software can inspect the cause.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Overflow  <= 1'b0;
      r_Underflow <= 1'b0;
    end else begin
      if (w_SetOverflow) begin
        r_Overflow <= 1'b1;
      end
      if (w_SetUnderflow) begin
        r_Underflow <= 1'b1;
      end
    end
  end

  assign o_Stack_Overflow  = r_Overflow;
  assign o_Stack_Underflow = r_Underflow;
  assign o_Depth           = r_Depth;

endmodule

// File: tb/tb_pc_jump_sequencer.sv
// Self-checking bench for pc_jump_sequencer: vector table plus hand-written
// multi-cycle sequences, all expectations routed through a scoreboard queue.
module tb_pc_jump_sequencer;

  localparam logic [2:0] OP_SEQ  = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_JZ   = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b101;
  localparam logic [2:0] OP_X6   = 3'b110;

  logic       i_Clk = 1'b0;
  logic       i_Rst_n;
  logic       i_Start;
  logic       i_Instr_Valid;
  logic [2:0] i_Op;
  logic       i_Flag_Z;
  logic [7:0] i_Target;
  logic [7:0] i_Pc_Actual;
  logic       o_Control_PC;
  logic [1:0] o_Control_Saltos;
  logic [7:0] o_Direccion_Salto;
  logic       o_Flush;
  logic       o_Halted;
  logic       o_Stack_Overflow;
  logic       o_Stack_Underflow;
  logic [2:0] o_Depth;

  always #5 i_Clk = ~i_Clk;

  pc_jump_sequencer #(.ADDR_W(8), .STACK_DEPTH(4), .DEPTH_W(3)) dut (
    .i_Clk             (i_Clk),
    .i_Rst_n           (i_Rst_n),
    .i_Start           (i_Start),
    .i_Instr_Valid     (i_Instr_Valid),
    .i_Op              (i_Op),
    .i_Flag_Z          (i_Flag_Z),
    .i_Target          (i_Target),
    .i_Pc_Actual       (i_Pc_Actual),
    .o_Control_PC      (o_Control_PC),
    .o_Control_Saltos  (o_Control_Saltos),
    .o_Direccion_Salto (o_Direccion_Salto),
    .o_Flush           (o_Flush),
    .o_Halted          (o_Halted),
    .o_Stack_Overflow  (o_Stack_Overflow),
    .o_Stack_Underflow (o_Stack_Underflow),
    .o_Depth           (o_Depth)
  );

  typedef struct {
    logic       start;
    logic       valid;
    logic [2:0] op;
    logic       z;
    logic [7:0] tgt;
    logic [7:0] pc;
    logic       cpc;
    logic [1:0] saltos;
    logic [7:0] salto;
    logic       flush;
    logic       halted;
    logic       ovf;
    logic       unf;
    logic [2:0] depth;
  } vec_t;

  vec_t expQ[$];
  vec_t table1[15];
  int   nChecks = 0;
  int   nFails  = 0;

  function automatic vec_t mk(input logic st, input logic va, input logic [2:0] op,
                              input logic z, input logic [7:0] tgt, input logic [7:0] pc,
                              input logic cpc, input logic [1:0] sa, input logic [7:0] sl,
                              input logic fl, input logic ha, input logic ov, input logic un,
                              input logic [2:0] dp);
    vec_t v;
    v.start = st; v.valid = va; v.op = op; v.z = z; v.tgt = tgt; v.pc = pc;
    v.cpc = cpc; v.saltos = sa; v.salto = sl; v.flush = fl; v.halted = ha;
    v.ovf = ov; v.unf = un; v.depth = dp;
    return v;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected for that cycle.
  task automatic applyStimulus(input vec_t v);
    i_Start       = v.start;
    i_Instr_Valid = v.valid;
    i_Op          = v.op;
    i_Flag_Z      = v.z;
    i_Target      = v.tgt;
    i_Pc_Actual   = v.pc;
    expQ.push_back(v);
  endtask

  // Compare mid-cycle outputs with the oldest queued expectation, then advance a cycle.
  task automatic checkOutput(input string name);
    vec_t e;
    #4;
    nChecks++;
    if (expQ.size() == 0) begin
      nFails++;
      $display("[TB] FAIL %s: scoreboard empty, got saltos=%b required an expectation", name, o_Control_Saltos);
    end else begin
      e = expQ.pop_front();
      if (o_Control_PC !== e.cpc || o_Control_Saltos !== e.saltos || o_Direccion_Salto !== e.salto ||
          o_Flush !== e.flush || o_Halted !== e.halted || o_Stack_Overflow !== e.ovf ||
          o_Stack_Underflow !== e.unf || o_Depth !== e.depth) begin
        nFails++;
        $display("[TB] FAIL %s: got pc=%b saltos=%b salto=%h flush=%b halt=%b ovf=%b unf=%b depth=%0d; required pc=%b saltos=%b salto=%h flush=%b halt=%b ovf=%b unf=%b depth=%0d",
                 name, o_Control_PC, o_Control_Saltos, o_Direccion_Salto, o_Flush, o_Halted,
                 o_Stack_Overflow, o_Stack_Underflow, o_Depth,
                 e.cpc, e.saltos, e.salto, e.flush, e.halted, e.ovf, e.unf, e.depth);
      end
    end
    @(posedge i_Clk);
    #1;
  endtask

  task automatic step(input string name, input vec_t v);
    applyStimulus(v);
    checkOutput(name);
  endtask

  task automatic doReset(input string name);
    i_Rst_n = 1'b0;
    step(name, mk(1, 1, OP_JMP, 1, 8'h77, 8'h00, 0, 2'b11, 8'h00, 0, 0, 0, 0, 3'd0));
    i_Rst_n = 1'b1;
  endtask

  task automatic doStart(input string name);
    step(name, mk(1, 0, OP_SEQ, 0, 8'h00, 8'h00, 0, 2'b11, 8'h00, 0, 0, 0, 0, 3'd0));
  endtask

  initial begin
    i_Rst_n = 1'b0; i_Start = 1'b0; i_Instr_Valid = 1'b0; i_Op = OP_SEQ;
    i_Flag_Z = 1'b0; i_Target = '0; i_Pc_Actual = '0;
    @(posedge i_Clk);
    #1;

    table1[0]  = mk(1, 0, OP_SEQ,  0, 8'h00, 8'h00, 0, 2'b11, 8'h00, 0, 0, 0, 0, 3'd0);
    table1[1]  = mk(0, 1, OP_SEQ,  0, 8'h00, 8'h00, 1, 2'b00, 8'h00, 0, 0, 0, 0, 3'd0);
    table1[2]  = mk(1, 1, OP_SEQ,  0, 8'h00, 8'h01, 1, 2'b00, 8'h00, 0, 0, 0, 0, 3'd0);
    table1[3]  = mk(0, 1, OP_SEQ,  1, 8'h99, 8'h02, 1, 2'b00, 8'h00, 0, 0, 0, 0, 3'd0);
    table1[4]  = mk(0, 1, OP_JZ,   0, 8'h40, 8'h03, 1, 2'b00, 8'h00, 0, 0, 0, 0, 3'd0);
    table1[5]  = mk(0, 1, OP_JZ,   1, 8'h40, 8'h04, 0, 2'b01, 8'h40, 0, 0, 0, 0, 3'd0);
    table1[6]  = mk(0, 1, OP_SEQ,  0, 8'h00, 8'h40, 0, 2'b11, 8'h00, 1, 0, 0, 0, 3'd0);
    table1[7]  = mk(0, 0, OP_SEQ,  0, 8'h00, 8'h40, 0, 2'b11, 8'h00, 0, 0, 0, 0, 3'd0);
    table1[8]  = mk(0, 1, OP_CALL, 0, 8'h80, 8'h10, 0, 2'b01, 8'h80, 0, 0, 0, 0, 3'd0);
    table1[9]  = mk(0, 1, OP_RET,  0, 8'h00, 8'h80, 0, 2'b11, 8'h00, 1, 0, 0, 0, 3'd1);
    table1[10] = mk(0, 1, OP_RET,  0, 8'h00, 8'h81, 0, 2'b01, 8'h11, 0, 0, 0, 0, 3'd1);
    table1[11] = mk(0, 0, OP_SEQ,  0, 8'h00, 8'h11, 0, 2'b11, 8'h00, 1, 0, 0, 0, 3'd0);
    table1[12] = mk(0, 1, OP_JMP,  0, 8'h33, 8'h11, 0, 2'b01, 8'h33, 0, 0, 0, 0, 3'd0);
    table1[13] = mk(0, 1, OP_JMP,  0, 8'h55, 8'h33, 0, 2'b11, 8'h00, 1, 0, 0, 0, 3'd0);
    table1[14] = mk(0, 1, OP_X6,   1, 8'h55, 8'h33, 1, 2'b00, 8'h00, 0, 0, 0, 0, 3'd0);

    doReset("reset_basic");
    for (int i = 0; i < 15; i++) begin
      step($sformatf("table_%0d", i), table1[i]);
    end

    // Nested calls until the stack overflows.
    doReset("reset_ovf");
    doStart("start_ovf");
    for (int i = 0; i < 4; i++) begin
      step($sformatf("call_%0d", i),
           mk(0, 1, OP_CALL, 0, 8'h50 + 8'(i), 8'h20 + 8'(i), 0, 2'b01, 8'h50 + 8'(i), 0, 0, 0, 0, 3'(i)));
      step($sformatf("call_flush_%0d", i),
           mk(0, 0, OP_SEQ, 0, 8'h00, 8'h00, 0, 2'b11, 8'h00, 1, 0, 0, 0, 3'(i + 1)));
    end
    step("call_5_full", mk(0, 1, OP_CALL, 0, 8'h60, 8'h30, 0, 2'b11, 8'h00, 0, 0, 0, 0, 3'd4));
    for (int i = 0; i < 3; i++) begin
      step($sformatf("fault_ovf_%0d", i),
           mk(1, 1, OP_SEQ, 0, 8'h00, 8'h31, 0, 2'b11, 8'h00, 0, 0, 1, 0, 3'd4));
    end

    // Empty-stack return, then wrapped return address and LIFO order.
    doReset("reset_unf");
    doStart("start_unf");
    step("ret_empty", mk(0, 1, OP_RET, 0, 8'h00, 8'h05, 0, 2'b11, 8'h00, 0, 0, 0, 0, 3'd0));
    step("fault_unf", mk(0, 1, OP_JMP, 0, 8'h22, 8'h05, 0, 2'b11, 8'h00, 0, 0, 0, 1, 3'd0));
    doReset("reset_wrap");
    doStart("start_wrap");
    step("call_ff",     mk(0, 1, OP_CALL, 0, 8'h10, 8'hFF, 0, 2'b01, 8'h10, 0, 0, 0, 0, 3'd0));
    step("flush_ff",    mk(0, 0, OP_SEQ,  0, 8'h00, 8'h10, 0, 2'b11, 8'h00, 1, 0, 0, 0, 3'd1));
    step("call_01",     mk(0, 1, OP_CALL, 0, 8'h20, 8'h01, 0, 2'b01, 8'h20, 0, 0, 0, 0, 3'd1));
    step("flush_01",    mk(0, 0, OP_SEQ,  0, 8'h00, 8'h20, 0, 2'b11, 8'h00, 1, 0, 0, 0, 3'd2));
    step("ret_inner",   mk(0, 1, OP_RET,  0, 8'h00, 8'h21, 0, 2'b01, 8'h02, 0, 0, 0, 0, 3'd2));
    step("flush_ri",    mk(0, 0, OP_SEQ,  0, 8'h00, 8'h02, 0, 2'b11, 8'h00, 1, 0, 0, 0, 3'd1));
    step("ret_wrap",    mk(0, 1, OP_RET,  0, 8'h00, 8'h03, 0, 2'b01, 8'h00, 0, 0, 0, 0, 3'd1));
    step("flush_rw",    mk(0, 0, OP_SEQ,  0, 8'h00, 8'h00, 0, 2'b11, 8'h00, 1, 0, 0, 0, 3'd0));

    // HALT is sticky until reset.
    doReset("reset_halt");
    doStart("start_halt");
    step("halt",        mk(0, 1, OP_HALT, 0, 8'h00, 8'h07, 0, 2'b11, 8'h00, 0, 0, 0, 0, 3'd0));
    step("halted_seq",  mk(1, 1, OP_SEQ,  0, 8'h00, 8'h07, 0, 2'b11, 8'h00, 0, 1, 0, 0, 3'd0));
    step("halted_jmp",  mk(0, 1, OP_JMP,  0, 8'h44, 8'h07, 0, 2'b11, 8'h00, 0, 1, 0, 0, 3'd0));

    // Reset asserted in the middle of a flush cycle.
    doReset("reset_mid");
    doStart("start_mid");
    step("call_mid",    mk(0, 1, OP_CALL, 0, 8'h90, 8'h08, 0, 2'b01, 8'h90, 0, 0, 0, 0, 3'd0));
    applyStimulus(mk(0, 1, OP_SEQ, 0, 8'h00, 8'h90, 0, 2'b11, 8'h00, 0, 0, 0, 0, 3'd0));
    #1;
    i_Rst_n = 1'b0;
    checkOutput("reset_in_flush");
    i_Rst_n = 1'b1;
    step("idle_after",  mk(0, 1, OP_SEQ, 0, 8'h00, 8'h00, 0, 2'b11, 8'h00, 0, 0, 0, 0, 3'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
